riscv_wb_arbiter: RTL and testbench

- Shares the register file's single write port between NUM_REQ writeback sources (ALU, LSU, MULDIV) using a round-robin arbiter with a valid/ready handshake.
- Holds a per-register busy scoreboard: set when an instruction issues with a destination register, cleared when that register's write is committed to the register file.
- Drives the register file write port from a registered stage.
- Provides a read-after-write / write-after-write hazard stall signal to the issue stage.

---
 rtl/riscv_wb_arbiter.sv | 117 +++++++++++
 tb/tb_riscv_wb_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_wb_arbiter.sv
// +------------------------------------------------------------------------+
// | riscv_wb_arbiter: round-robin writeback arbiter, busy scoreboard and   |
// | hazard detection for the register file's single write port. Rev 1.0   |
// +------------------------------------------------------------------------+
`default_nettype none

module riscv_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [NUM_REQ*5-1:0]    req_rd_i,
  input  logic [NUM_REQ*XLEN-1:0] req_data_i,
  input  logic                    issue_valid_i,
  input  logic [4:0]              issue_rd_i,
  input  logic [4:0]              rs1_addr_i,
  input  logic [4:0]              rs2_addr_i,
  output logic                    hazard_o,
  output logic                    rd_wen_o,
  output logic [4:0]              rd_addr_o,
  output logic [XLEN-1:0]         rd_data_o,
  output logic [31:0]             busy_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               wen_q, wen_d;
  logic [4:0]         addr_q, addr_d;
  logic [XLEN-1:0]    data_q, data_d;
  logic [31:0]        busy_q, busy_d;

  logic               w_found;
  logic [PTR_W-1:0]   w_winner;
  logic [NUM_REQ-1:0] w_grant;
  logic [4:0]         w_win_rd;
  logic [XLEN-1:0]    w_win_data;

  // Rotating priority search; the grant is suppressed while reset is held.
  always_comb begin
    int idx;
    w_found  = 1'b0;
    w_winner = '0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_found && req_valid_i[idx] && reset_n) begin
        w_found  = 1'b1;
        w_winner = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    w_grant = '0;
    if (w_found) w_grant[w_winner] = 1'b1;
    w_win_rd   = req_rd_i[int'(w_winner)*5 +: 5];
    w_win_data = req_data_i[int'(w_winner)*XLEN +: XLEN];
  end

  always_comb begin
    ptr_d  = ptr_q;
    wen_d  = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (w_found) begin
      ptr_d  = (w_winner == PTR_W'(NUM_REQ-1)) ? '0 : w_winner + PTR_W'(1);
      wen_d  = (w_win_rd != 5'd0);
      addr_d = w_win_rd;
      data_d = w_win_data;
    end
  end

  // Clear on commit first so a same-edge issue to that register stays busy.
  always_comb begin
    busy_d = busy_q;
    if (wen_q) busy_d[addr_q] = 1'b0;
    if (issue_valid_i && (issue_rd_i != 5'd0)) busy_d[issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q  <= '0;
      wen_q  <= 1'b0;
      addr_q <= 5'd0;
      data_q <= '0;
      busy_q <= 32'd0;
    end else begin
      ptr_q  <= ptr_d;
      wen_q  <= wen_d;
      addr_q <= addr_d;
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  // No bypass: a register committing this cycle still reads as busy.
  always_comb begin
    hazard_o = ((rs1_addr_i != 5'd0) && busy_q[rs1_addr_i]) ||
               ((rs2_addr_i != 5'd0) && busy_q[rs2_addr_i]) ||
               (issue_valid_i && (issue_rd_i != 5'd0) && busy_q[issue_rd_i]);
  end

  assign req_ready_o = w_grant;
  assign rd_wen_o    = wen_q;
  assign rd_addr_o   = addr_q;
  assign rd_data_o   = data_q;
  assign busy_o      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_riscv_wb_arbiter.sv
// +------------------------------------------------------------------------+
// | tb_riscv_wb_arbiter: directed and random bench for riscv_wb_arbiter.   |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_riscv_wb_arbiter;

  localparam int N    = 3;
  localparam int XLEN = 32;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [N-1:0]      req_valid_i;
  logic [N-1:0]      req_ready_o;
  logic [N*5-1:0]    req_rd_i;
  logic [N*XLEN-1:0] req_data_i;
  logic              issue_valid_i;
  logic [4:0]        issue_rd_i, rs1_addr_i, rs2_addr_i;
  logic              hazard_o, rd_wen_o;
  logic [4:0]        rd_addr_o;
  logic [XLEN-1:0]   rd_data_o;
  logic [31:0]       busy_o;

  always #5 clock = ~clock;

  riscv_wb_arbiter #(.NUM_REQ(N), .XLEN(XLEN)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_rd_i(req_rd_i), .req_data_i(req_data_i),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .hazard_o(hazard_o), .rd_wen_o(rd_wen_o), .rd_addr_o(rd_addr_o),
    .rd_data_o(rd_data_o), .busy_o(busy_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: rotating-priority pointer, busy array, pending write.
  int          m_ptr = 0;
  bit          m_busy [32];
  bit          m_wen = 1'b0;
  int          m_addr = 0;
  logic [31:0] m_data = '0;

  always @(negedge clock) begin : cmp
    int          win;
    logic [N-1:0] eg;
    logic [31:0] eb;
    logic        eh;
    if (!reset_n) begin
      chk("m_rst_ready", 64'(req_ready_o), 64'd0);
      chk("m_rst_wen", 64'(rd_wen_o), 64'd0);
      chk("m_rst_busy", 64'(busy_o), 64'd0);
      chk("m_rst_hazard", 64'(hazard_o), 64'd0);
      m_ptr = 0;
      m_wen = 1'b0;
      foreach (m_busy[r]) m_busy[r] = 1'b0;
    end else begin
      win = -1;
      for (int k = 0; k < N; k++)
        if (win < 0 && req_valid_i[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      eg = '0;
      if (win >= 0) eg[win] = 1'b1;
      for (int r = 0; r < 32; r++) eb[r] = m_busy[r];
      eh = (rs1_addr_i != 0 && m_busy[rs1_addr_i]) ||
           (rs2_addr_i != 0 && m_busy[rs2_addr_i]) ||
           (issue_valid_i && issue_rd_i != 0 && m_busy[issue_rd_i]);
      chk("m_ready", 64'(req_ready_o), 64'(eg));
      chk("m_hazard", 64'(hazard_o), 64'(eh));
      chk("m_busy", 64'(busy_o), 64'(eb));
      chk("m_wen", 64'(rd_wen_o), 64'(m_wen));
      if (m_wen) begin
        chk("m_addr", 64'(rd_addr_o), 64'(m_addr));
        chk("m_data", 64'(rd_data_o), 64'(m_data));
      end
      if (m_wen) m_busy[m_addr] = 1'b0;
      if (issue_valid_i && issue_rd_i != 0) m_busy[issue_rd_i] = 1'b1;
      if (win >= 0) begin
        m_ptr  = (win + 1) % N;
        m_addr = int'(req_rd_i[win*5 +: 5]);
        m_data = req_data_i[win*XLEN +: XLEN];
        m_wen  = (m_addr != 0);
      end else begin
        m_wen = 1'b0;
      end
    end
  end

  task automatic idle();
    req_valid_i = '0; req_rd_i = '0; req_data_i = '0;
    issue_valid_i = 1'b0; issue_rd_i = '0; rs1_addr_i = '0; rs2_addr_i = '0;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
    req_valid_i[i] = v;
    req_rd_i[i*5 +: 5] = rd;
    req_data_i[i*XLEN +: XLEN] = d;
  endtask

  task automatic next_cycle();
    @(posedge clock); #1;
  endtask

  logic [N-1:0] rr_exp [6];

  initial begin
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    idle();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 1), 32'h100 + 32'(i));
    repeat (3) begin
      @(negedge clock);
      chk("rst_ready", 64'(req_ready_o), 64'd0);
      chk("rst_wen", 64'(rd_wen_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
    end
    next_cycle(); reset_n = 1'b1; idle();

    // Single write from the ALU
    next_cycle(); set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    @(negedge clock); chk("sw_grant", 64'(req_ready_o), 64'b001);
    next_cycle(); idle();
    @(negedge clock);
    chk("sw_wen", 64'(rd_wen_o), 64'd1);
    chk("sw_addr", 64'(rd_addr_o), 64'd5);
    chk("sw_data", 64'(rd_data_o), 64'hDEADBEEF);
    next_cycle();
    @(negedge clock); chk("sw_wen_off", 64'(rd_wen_o), 64'd0);

    // Round robin from a fresh pointer, then a mid-run reset
    next_cycle(); reset_n = 1'b0;
    next_cycle(); reset_n = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 1), 32'hA0 + 32'(i));
    for (int j = 0; j < 6; j++) begin
      @(negedge clock); chk("rr_grant", 64'(req_ready_o), 64'(rr_exp[j]));
      next_cycle();
    end
    @(negedge clock); chk("rr_wen_before_rst", 64'(rd_wen_o), 64'd1);
    next_cycle(); reset_n = 1'b0;
    @(negedge clock);
    chk("mid_rst_ready", 64'(req_ready_o), 64'd0);
    chk("mid_rst_wen", 64'(rd_wen_o), 64'd0);
    chk("mid_rst_addr", 64'(rd_addr_o), 64'd0);
    chk("mid_rst_data", 64'(rd_data_o), 64'd0);
    next_cycle(); reset_n = 1'b1;
    @(negedge clock); chk("mid_rst_ptr0", 64'(req_ready_o), 64'b001);

    // Scoreboard: issue x7, LSU writes x7 at t+4
    next_cycle(); idle(); issue_valid_i = 1'b1; issue_rd_i = 5'd7;
    next_cycle(); issue_valid_i = 1'b0; rs1_addr_i = 5'd7;
    @(negedge clock);
    chk("sb_busy7", 64'(busy_o[7]), 64'd1);
    chk("sb_haz_t1", 64'(hazard_o), 64'd1);
    next_cycle();
    next_cycle(); set_req(1, 1'b1, 5'd7, 32'h0000_7777);
    @(negedge clock);
    chk("sb_lsu_grant", 64'(req_ready_o), 64'b010);
    chk("sb_haz_t4", 64'(hazard_o), 64'd1);
    next_cycle(); set_req(1, 1'b0, 5'd0, 32'd0);
    @(negedge clock);
    chk("sb_wen_t5", 64'(rd_wen_o), 64'd1);
    chk("sb_addr_t5", 64'(rd_addr_o), 64'd7);
    chk("sb_haz_t5", 64'(hazard_o), 64'd1);
    next_cycle();
    @(negedge clock);
    chk("sb_busy7_clr", 64'(busy_o[7]), 64'd0);
    chk("sb_haz_t6", 64'(hazard_o), 64'd0);

    // Same-edge set and clear of x9
    next_cycle(); idle(); set_req(1, 1'b1, 5'd9, 32'h9999);
    next_cycle(); idle(); issue_valid_i = 1'b1; issue_rd_i = 5'd9;
    @(negedge clock);
    chk("sc_wen", 64'(rd_wen_o), 64'd1);
    chk("sc_addr", 64'(rd_addr_o), 64'd9);
    next_cycle(); idle();
    @(negedge clock); chk("sc_busy9", 64'(busy_o), 64'h0000_0200);

    // x0 never becomes busy and never writes
    next_cycle(); issue_valid_i = 1'b1; issue_rd_i = 5'd0; set_req(2, 1'b1, 5'd0, 32'h1234);
    @(negedge clock); chk("x0_grant", 64'(req_ready_o), 64'b100);
    next_cycle(); idle();
    @(negedge clock);
    chk("x0_wen", 64'(rd_wen_o), 64'd0);
    chk("x0_busy", 64'(busy_o), 64'h0000_0200);

    // Random traffic with occasional one-cycle resets
    repeat (3000) begin
      next_cycle();
      reset_n       = ($urandom_range(0, 99) != 0);
      req_valid_i   = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_rd_i[i*5 +: 5] = 5'($urandom_range(0, 15));
        req_data_i[i*XLEN +: XLEN] = $urandom;
      end
      issue_valid_i = 1'($urandom);
      issue_rd_i    = 5'($urandom_range(0, 15));
      rs1_addr_i    = 5'($urandom_range(0, 15));
      rs2_addr_i    = 5'($urandom_range(0, 15));
    end
    next_cycle(); reset_n = 1'b1; idle();
    repeat (3) next_cycle();
    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
